// File: rtl/aes_inv_round_engine.sv
// aes_inv_round_engine: iterative AES inverse cipher (AES-128/192/256).
// One 128-bit block at a time. Round keys are fetched through a
// request/valid port, and the plaintext leaves through a valid/ready port.
// Byte (row r, column c) is held at bits [32r+8c+7 : 32r+8c].
// Optional feature: define AES_INV_ABORT_EN to add the 'abort' input.
// Abort returns the engine to IDLE from any busy state.
module aes_inv_round_engine #(
    parameter int NUM_ROUNDS = 10,
    parameter int SBOX_LANES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef AES_INV_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         key_req,
    output logic [3:0]   key_idx,
    input  logic         key_valid,
    input  logic [127:0] key_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [3:0]   round_cnt
);

    // InvSubBytes takes SUB_CYCLES passes of SBOX_LANES bytes each.
    localparam int         SUB_CYCLES = 16 / SBOX_LANES;
    localparam logic [3:0] NR         = 4'(NUM_ROUNDS);
    localparam logic [3:0] NR_M1      = 4'(NUM_ROUNDS - 1);
    localparam logic [1:0] LANE_LAST  = 2'(SUB_CYCLES - 1);

    // Reject illegal configurations during elaboration.
    generate
        if (!(NUM_ROUNDS == 10 || NUM_ROUNDS == 12 || NUM_ROUNDS == 14)) begin : g_bad_rounds
            $error("aes_inv_round_engine: NUM_ROUNDS must be 10, 12 or 14");
        end
        if (!(SBOX_LANES == 4 || SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
            $error("aes_inv_round_engine: SBOX_LANES must be 4, 8 or 16");
        end
    endgenerate

    // Inverse S-box. Entry x sits at bits [8*(255-x)+7 : 8*(255-x)].
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEY0  = 3'd1,
        SHIFT = 3'd2,
        SUB   = 3'd3,
        KEY   = 3'd4,
        MIX   = 3'd5,
        DONE  = 3'd6
    } state_e;

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[8 * (255 - int'(x)) +: 8];
    endfunction

    // Multiply by x (0x02) modulo 0x11B.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One output byte of InvMixColumns: 14*a0 ^ 11*a1 ^ 13*a2 ^ 9*a3.
    function automatic logic [7:0] inv_mix_byte(input logic [7:0] a0, input logic [7:0] a1,
                                                input logic [7:0] a2, input logic [7:0] a3);
        logic [7:0] m14, m11, m13, m9;
        m14 = xt(xt(xt(a0))) ^ xt(xt(a0)) ^ xt(a0);
        m11 = xt(xt(xt(a1))) ^ xt(a1) ^ a1;
        m13 = xt(xt(xt(a2))) ^ xt(xt(a2)) ^ a2;
        m9  = xt(xt(xt(a3))) ^ a3;
        return m14 ^ m11 ^ m13 ^ m9;
    endfunction

    state_e       fsm_q;
    logic [127:0] blk_q;
    logic [127:0] out_data_q;
    logic [3:0]   round_cnt_q;
    logic [3:0]   key_idx_q;
    logic [1:0]   lane_q;
    logic         key_req_q;
    logic         out_valid_q;
    logic         busy_q;
    logic         in_ready_q;

    logic [127:0] shift_d;
    logic [127:0] sub_d;
    logic [127:0] mix_d;
    logic [127:0] ark_d;
    logic [7:0]   lane_in  [SBOX_LANES];
    logic [7:0]   lane_out [SBOX_LANES];

    // AddRoundKey is shared by the initial whitening step and every round.
    assign ark_d = blk_q ^ key_data;

    // InvShiftRows: row r rotates right by r columns.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_shift_row
            for (genvar gc = 0; gc < 4; gc++) begin : g_shift_col
                assign shift_d[32*gi + 8*gc +: 8] = blk_q[32*gi + 8*((gc - gi + 4) % 4) +: 8];
            end
        end
    endgenerate

    // InvMixColumns. Each column holds byte c of rows 0..3.
    generate
        for (genvar gc = 0; gc < 4; gc++) begin : g_mix_col
            for (genvar gi = 0; gi < 4; gi++) begin : g_mix_row
                assign mix_d[32*gi + 8*gc +: 8] = inv_mix_byte(
                    blk_q[32*gi             + 8*gc +: 8],
                    blk_q[32*((gi + 1) % 4) + 8*gc +: 8],
                    blk_q[32*((gi + 2) % 4) + 8*gc +: 8],
                    blk_q[32*((gi + 3) % 4) + 8*gc +: 8]);
            end
        end
    endgenerate

    // The S-box lanes read the group of bytes chosen by lane_q.
    // Bytes are handled in ascending order, SBOX_LANES at a time.
    generate
        for (genvar gi = 0; gi < SBOX_LANES; gi++) begin : g_lane
            assign lane_in[gi]  = blk_q[8 * (int'(lane_q) * SBOX_LANES + gi) +: 8];
            assign lane_out[gi] = inv_sbox(lane_in[gi]);
        end
    endgenerate

    // Merge the substituted lane group back into the state.
    always_comb begin
        sub_d = blk_q;
        for (int i = 0; i < 16; i++) begin
            if ((i / SBOX_LANES) == int'(lane_q)) begin
                sub_d[8*i +: 8] = lane_out[i % SBOX_LANES];
            end
        end
    end

    // Control FSM. It updates the datapath registers and the registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            blk_q       <= '0;
            out_data_q  <= '0;
            round_cnt_q <= '0;
            key_idx_q   <= '0;
            lane_q      <= '0;
            key_req_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end
`ifdef AES_INV_ABORT_EN
        else if (abort && fsm_q != IDLE) begin
            fsm_q       <= IDLE;
            blk_q       <= '0;
            out_data_q  <= '0;
            lane_q      <= '0;
            key_req_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end
`endif
        else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        blk_q       <= in_data;
                        round_cnt_q <= NR;
                        key_idx_q   <= NR;
                        key_req_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        in_ready_q  <= 1'b0;
                        fsm_q       <= KEY0;
                    end
                end
                KEY0: begin
                    if (key_valid) begin
                        blk_q       <= ark_d;
                        round_cnt_q <= NR_M1;
                        key_req_q   <= 1'b0;
                        fsm_q       <= SHIFT;
                    end
                end
                SHIFT: begin
                    blk_q  <= shift_d;
                    lane_q <= '0;
                    fsm_q  <= SUB;
                end
                SUB: begin
                    blk_q <= sub_d;
                    if (lane_q == LANE_LAST) begin
                        lane_q    <= '0;
                        key_idx_q <= round_cnt_q;
                        key_req_q <= 1'b1;
                        fsm_q     <= KEY;
                    end else begin
                        lane_q <= lane_q + 2'd1;
                    end
                end
                KEY: begin
                    if (key_valid) begin
                        blk_q     <= ark_d;
                        key_req_q <= 1'b0;
                        if (round_cnt_q != 4'd0) begin
                            fsm_q <= MIX;
                        end else begin
                            out_data_q  <= ark_d;
                            out_valid_q <= 1'b1;
                            fsm_q       <= DONE;
                        end
                    end
                end
                MIX: begin
                    blk_q       <= mix_d;
                    round_cnt_q <= round_cnt_q - 4'd1;
                    fsm_q       <= SHIFT;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= IDLE;
                    end
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign key_req   = key_req_q;
    assign key_idx   = key_idx_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign round_cnt = round_cnt_q;

endmodule
